// File: rtl/timer_pkg.sv
// Shared definitions for the AXI4-Lite timer peripheral: register map,
// control bit positions, response codes, channel FSM states.
package timer_pkg;

   localparam logic [2:0] CTRL_OFF     = 3'd0;
   localparam logic [2:0] PRESCALE_OFF = 3'd1;
   localparam logic [2:0] LOAD_OFF     = 3'd2;
   localparam logic [2:0] COUNT_OFF    = 3'd3;
   localparam logic [2:0] STATUS_OFF   = 3'd4;
   localparam logic [2:0] ID_OFF       = 3'd5;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_RELOAD_BIT = 2;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   // Byte-lane merge of a write beat into an existing register value.
   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_timer_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the timer (slave).
interface axi_lite_timer_slave_if #(
   parameter int ADDR_BW_p = 15
);
   logic [ADDR_BW_p-1:0] awaddr_i;
   logic                 awvalid_i;
   logic                 awready_o;
   logic [31:0]          wdata_i;
   logic [3:0]           wstrb_i;
   logic                 wvalid_i;
   logic                 wready_o;
   logic [1:0]           bresp_o;
   logic                 bvalid_o;
   logic                 bready_i;
   logic [ADDR_BW_p-1:0] araddr_i;
   logic                 arvalid_i;
   logic                 arready_o;
   logic [31:0]          rdata_o;
   logic [1:0]           rresp_o;
   logic                 rvalid_o;
   logic                 rready_i;

   modport slave (
      input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
             araddr_i, arvalid_i, rready_i,
      output awready_o, wready_o, bresp_o, bvalid_o,
             arready_o, rdata_o, rresp_o, rvalid_o
   );

   modport master (
      output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
             araddr_i, arvalid_i, rready_i,
      input  awready_o, wready_o, bresp_o, bvalid_o,
             arready_o, rdata_o, rresp_o, rvalid_o
   );
endinterface

// File: rtl/timer_core.sv
// Prescaler, 32-bit down-counter with auto-reload and sticky EXPIRED flag.
// Software register writes arrive as decoded one-cycle strobes.
module timer_core
   import timer_pkg::*;
#(
   parameter int PRESCALE_BW_p = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_ctrl,
   input  logic                     wr_prescale,
   input  logic                     wr_load,
   input  logic                     wr_count,
   input  logic                     wr_status,
   input  logic [31:0]              wdata,
   input  logic [3:0]               wstrb,
   output logic [2:0]               ctrl,
   output logic [PRESCALE_BW_p-1:0] prescale,
   output logic [31:0]              load,
   output logic [31:0]              count,
   output logic                     expired
);

   logic [PRESCALE_BW_p-1:0] presc_q;
   logic [2:0]               ctrl_wr_val;
   logic                     tick;
   logic                     cnt_zero;
   logic                     en_rise;

   assign ctrl_wr_val = 3'(strb_merge({29'b0, ctrl}, wdata, wstrb));
   assign tick        = ctrl[CTRL_EN_BIT] && (presc_q == prescale);
   assign cnt_zero    = (count == 32'd0);
   assign en_rise     = wr_ctrl && ctrl_wr_val[CTRL_EN_BIT] && !ctrl[CTRL_EN_BIT];

   // Software writes are checked first so they override the hardware update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q  <= '0;
         ctrl     <= '0;
         prescale <= '0;
         load     <= '0;
         count    <= '0;
         expired  <= 1'b0;
      end else begin
         if (wr_prescale) prescale <= PRESCALE_BW_p'(strb_merge(32'(prescale), wdata, wstrb));
         if (wr_load)     load     <= strb_merge(load, wdata, wstrb);

         if (wr_count || en_rise || tick) presc_q <= '0;
         else if (ctrl[CTRL_EN_BIT])      presc_q <= presc_q + PRESCALE_BW_p'(1);

         if (wr_count)       count <= strb_merge(count, wdata, wstrb);
         else if (tick)      count <= cnt_zero ? (ctrl[CTRL_RELOAD_BIT] ? load : 32'd0)
                                               : count - 32'd1;

         if (wr_ctrl) ctrl <= ctrl_wr_val;
         else if (tick && cnt_zero && !ctrl[CTRL_RELOAD_BIT]) ctrl[CTRL_EN_BIT] <= 1'b0;

         // A new expiry beats a simultaneous write-1-to-clear.
         if (tick && cnt_zero)                        expired <= 1'b1;
         else if (wr_status && wstrb[0] && wdata[0])  expired <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_lite_timer_slave.sv
// AXI4-Lite responder for the SoC timer: independent write/read channel FSMs,
// register decode, and the timer core.
module axi_lite_timer_slave
   import timer_pkg::*;
#(
   parameter int          ADDR_BW_p     = 15,
   parameter int          DATA_BW_p     = 32,
   parameter int          PRESCALE_BW_p = 16,
   parameter logic [31:0] ID_VALUE_p    = 32'h5449_4D31
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   axi_lite_timer_slave_if.slave  bus,
   output logic                   irq_o
);

   if (DATA_BW_p != 32) begin : g_bad_data_bw
      $error("axi_lite_timer_slave: DATA_BW_p must be 32");
   end
   if (ADDR_BW_p < 5) begin : g_bad_addr_bw
      $error("axi_lite_timer_slave: ADDR_BW_p must cover bits [4:2]");
   end

   w_state_t w_state_q, w_state_d;
   r_state_t r_state_q, r_state_d;
   logic        aw_got_q, w_got_q;
   logic [2:0]  aw_off_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   resp_t       bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic        aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
   logic        aw_hs, w_hs, wr_commit;
   logic [2:0]  wr_off, rd_off;
   logic [31:0] wr_data, rd_data;
   logic [3:0]  wr_strb;
   logic        rd_ok;
   logic        addr_unused;

   logic [2:0]               ctrl;
   logic [PRESCALE_BW_p-1:0] prescale;
   logic [31:0]              load, count;
   logic                     expired;

   assign addr_unused = ^{bus.awaddr_i, bus.araddr_i};

   // Write channel: AW and W captured independently, committed together.
   assign aw_hs     = bus.awvalid_i && aw_rdy;
   assign w_hs      = bus.wvalid_i && w_rdy;
   assign wr_commit = (w_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
   assign wr_off    = aw_hs ? bus.awaddr_i[4:2] : aw_off_q;
   assign wr_data   = w_hs ? bus.wdata_i : wdata_q;
   assign wr_strb   = w_hs ? bus.wstrb_i : wstrb_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         aw_off_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= OKAY;
      end else begin
         w_state_q <= w_state_d;
         if (aw_hs) aw_off_q <= bus.awaddr_i[4:2];
         if (w_hs) begin
            wdata_q <= bus.wdata_i;
            wstrb_q <= bus.wstrb_i;
         end
         if (wr_commit) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            bresp_q  <= (wr_off <= STATUS_OFF) ? OKAY : SLVERR;
         end else begin
            if (aw_hs) aw_got_q <= 1'b1;
            if (w_hs)  w_got_q  <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (wr_commit)    w_state_d = W_RESP;
         W_RESP:  if (bus.bready_i) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      b_vld  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_rdy = !aw_got_q;
            w_rdy  = !w_got_q;
         end
         W_RESP:  b_vld = 1'b1;
         default: ;
      endcase
   end

   // Read channel: data is snapshotted at the AR handshake and held.
   assign rd_off = bus.araddr_i[4:2];

   always_comb begin
      rd_data = '0;
      rd_ok   = 1'b1;
      case (rd_off)
         CTRL_OFF:     rd_data = {29'b0, ctrl};
         PRESCALE_OFF: rd_data = 32'(prescale);
         LOAD_OFF:     rd_data = load;
         COUNT_OFF:    rd_data = count;
         STATUS_OFF:   rd_data = {31'b0, expired};
         ID_OFF:       rd_data = ID_VALUE_p;
         default:      rd_ok   = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         r_state_q <= r_state_d;
         if (bus.arvalid_i && ar_rdy) begin
            rdata_q <= rd_data;
            rresp_q <= rd_ok ? OKAY : SLVERR;
         end
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (bus.arvalid_i) r_state_d = R_DATA;
         R_DATA:  if (bus.rready_i)  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      ar_rdy = (r_state_q == R_IDLE);
      r_vld  = (r_state_q == R_DATA);
   end

   assign bus.awready_o = aw_rdy;
   assign bus.wready_o  = w_rdy;
   assign bus.bvalid_o  = b_vld;
   assign bus.bresp_o   = bresp_q;
   assign bus.arready_o = ar_rdy;
   assign bus.rvalid_o  = r_vld;
   assign bus.rdata_o   = rdata_q;
   assign bus.rresp_o   = rresp_q;

   timer_core #(
      .PRESCALE_BW_p(PRESCALE_BW_p)
   ) u_core (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_ctrl     (wr_commit && (wr_off == CTRL_OFF)),
      .wr_prescale (wr_commit && (wr_off == PRESCALE_OFF)),
      .wr_load     (wr_commit && (wr_off == LOAD_OFF)),
      .wr_count    (wr_commit && (wr_off == COUNT_OFF)),
      .wr_status   (wr_commit && (wr_off == STATUS_OFF)),
      .wdata       (wr_data),
      .wstrb       (wr_strb),
      .ctrl        (ctrl),
      .prescale    (prescale),
      .load        (load),
      .count       (count),
      .expired     (expired)
   );

   assign irq_o = expired & ctrl[CTRL_IRQ_EN_BIT];

endmodule
